// File: rtl/wb_port_latency_monitor_pkg.sv
// Shared types and helpers for the Wishbone port latency monitor.
// Optional simulation diagnostics are enabled with the macro WB_LATMON_CHECK_EN.
package wb_latmon_pkg;

  // Per-port measurement state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } latmon_state_e;

  // Reset value of the per-port minimum. Callers truncate it to their latency width.
  localparam logic [63:0] MIN_RESET = '1;

  // Adds a and b and clamps the result to the largest value that fits in 'width' bits.
  // 'width' must be 64 or less.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << width) - 65'd1;
    if (sum > lim) begin
      return lim[63:0];
    end
    return sum[63:0];
  endfunction

endpackage

// File: rtl/wb_port_latency_monitor_if.sv
// Bundle of tapped Wishbone handshake lines, one bit per monitored port.
interface wb_port_latency_monitor_if #(
  parameter int WB_PORTS = 3
);
  logic [WB_PORTS-1:0] cyc;
  logic [WB_PORTS-1:0] stb;
  logic [WB_PORTS-1:0] ack;

  modport master  (output cyc, output stb, input ack);
  modport slave   (input cyc, input stb, output ack);
  // The latency monitor only observes the bus.
  modport monitor (input cyc, input stb, input ack);
endinterface

// File: rtl/wb_port_latency_monitor_chan.sv
// One monitored port: latency measurement FSM plus its statistics registers.
// With WB_LATMON_CHECK_EN defined, simulation-only diagnostics are compiled in.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction open; waiting for cyc&stb
// WAIT  | transaction started; counting cycles until the first ack
// HOLD  | first ack seen or timed out; ignore burst beats until cyc drops
module wb_latmon_chan
  import wb_latmon_pkg::*;
#(
  parameter int LAT_WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 24,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cyc,
  input  logic                 stb,
  input  logic                 ack,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic [ACC_WIDTH-1:0] total,
  output logic [LAT_WIDTH-1:0] min_lat,
  output logic [LAT_WIDTH-1:0] max_lat,
  output logic                 timeout,
  output logic                 busy
);

  localparam logic [LAT_WIDTH-1:0] LAT_TO  = LAT_WIDTH'(TIMEOUT);
  localparam logic [LAT_WIDTH-1:0] LAT_MIN = LAT_WIDTH'(MIN_RESET);

  latmon_state_e        state_q, state_d;
  logic [LAT_WIDTH-1:0] lat_q, lat_d;
  logic [LAT_WIDTH-1:0] lat_incr;
  logic [LAT_WIDTH-1:0] rec_lat;
  logic                 rec;
  logic                 set_timeout;

  // Latency including the current cycle, held at all-ones once saturated.
  assign lat_incr = (lat_q == '1) ? lat_q : lat_q + LAT_WIDTH'(1);

  // State, latency counter and busy flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      busy    <= (state_d == WAIT);
    end
  end

  // Next-state decode; abort (cyc low) takes priority over ack and timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cyc && stb) begin
          state_d = ack ? HOLD : WAIT;
        end
      end
      WAIT: begin
        if (!cyc) begin
          state_d = IDLE;
        end else if (ack || (lat_incr == LAT_TO)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!cyc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter update and record/timeout strobes for the current cycle.
  always_comb begin
    lat_d       = lat_q;
    rec         = 1'b0;
    rec_lat     = '0;
    set_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (cyc && stb) begin
          lat_d = LAT_WIDTH'(1);
          if (ack) begin
            rec     = 1'b1;
            rec_lat = LAT_WIDTH'(1);
          end
        end
      end
      WAIT: begin
        if (cyc) begin
          lat_d = lat_incr;
          if (ack) begin
            rec     = 1'b1;
            rec_lat = lat_incr;
          end else if (lat_incr == LAT_TO) begin
            set_timeout = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Statistics; a clear in the same cycle as a record discards the record.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count   <= '0;
      total   <= '0;
      min_lat <= LAT_MIN;
      max_lat <= '0;
      timeout <= 1'b0;
    end else begin
      if (rec) begin
        count <= CNT_WIDTH'(sat_add(64'(count), 64'd1, CNT_WIDTH));
        total <= ACC_WIDTH'(sat_add(64'(total), 64'(rec_lat), ACC_WIDTH));
        if (rec_lat < min_lat) begin
          min_lat <= rec_lat;
        end
        if (rec_lat > max_lat) begin
          max_lat <= rec_lat;
        end
      end
      if (set_timeout) begin
        timeout <= 1'b1;
      end
    end
  end

`ifdef WB_LATMON_CHECK_EN
  // Simulation-only diagnostics; %m identifies the port through the generate index.
  always @(posedge clk) begin
    if (!rst) begin
      if (set_timeout) begin
        $error("%m: latency timeout at %0t", $time);
      end
      if ((state_q == IDLE) && ack && !cyc) begin
        $error("%m: ack without cyc while idle at %0t", $time);
      end
      if (rec) begin
        $display("%m: latency %0d recorded at %0t", rec_lat, $time);
      end
    end
  end
`else
  // Diagnostics are not built; behaviour is unchanged.
`endif

endmodule

// File: rtl/wb_port_latency_monitor.sv
// Passive multi-port Wishbone latency monitor: one measurement channel per port
// and a registered statistics readout selected by stat_port_i.
// Optional simulation diagnostics are enabled with the macro WB_LATMON_CHECK_EN.
module wb_port_latency_monitor
  import wb_latmon_pkg::*;
#(
  parameter int WB_PORTS  = 3,
  parameter int LAT_WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 24,
  parameter int TIMEOUT   = 1024,
  localparam int SEL_W    = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1
) (
  input  logic                          wb_clk,
  input  logic                          wb_rst,
  wb_port_latency_monitor_if.monitor    wb,
  input  logic [SEL_W-1:0]              stat_port_i,
  input  logic [WB_PORTS-1:0]           stat_clr_i,
  output logic [CNT_WIDTH-1:0]          stat_count_o,
  output logic [ACC_WIDTH-1:0]          stat_total_o,
  output logic [LAT_WIDTH-1:0]          stat_min_o,
  output logic [LAT_WIDTH-1:0]          stat_max_o,
  output logic                          stat_timeout_o,
  output logic [WB_PORTS-1:0]           busy_o
);

  logic [CNT_WIDTH-1:0] chan_count   [WB_PORTS];
  logic [ACC_WIDTH-1:0] chan_total   [WB_PORTS];
  logic [LAT_WIDTH-1:0] chan_min     [WB_PORTS];
  logic [LAT_WIDTH-1:0] chan_max     [WB_PORTS];
  logic [WB_PORTS-1:0]  chan_timeout;

  logic [CNT_WIDTH-1:0] sel_count;
  logic [ACC_WIDTH-1:0] sel_total;
  logic [LAT_WIDTH-1:0] sel_min;
  logic [LAT_WIDTH-1:0] sel_max;
  logic                 sel_timeout;

  for (genvar p = 0; p < WB_PORTS; p++) begin : g_chan
    wb_latmon_chan #(
      .LAT_WIDTH (LAT_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .CNT_WIDTH (CNT_WIDTH),
      .TIMEOUT   (TIMEOUT)
    ) u_chan (
      .clk     (wb_clk),
      .rst     (wb_rst),
      .cyc     (wb.cyc[p]),
      .stb     (wb.stb[p]),
      .ack     (wb.ack[p]),
      .clr     (stat_clr_i[p]),
      .count   (chan_count[p]),
      .total   (chan_total[p]),
      .min_lat (chan_min[p]),
      .max_lat (chan_max[p]),
      .timeout (chan_timeout[p]),
      .busy    (busy_o[p])
    );
  end

  // Readout mux; an index past the last port reads all zeros, min included.
  always_comb begin
    sel_count   = '0;
    sel_total   = '0;
    sel_min     = '0;
    sel_max     = '0;
    sel_timeout = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (stat_port_i == SEL_W'(p)) begin
        sel_count   = chan_count[p];
        sel_total   = chan_total[p];
        sel_min     = chan_min[p];
        sel_max     = chan_max[p];
        sel_timeout = chan_timeout[p];
      end
    end
  end

  // Registered readout, one cycle behind stat_port_i.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      stat_count_o   <= '0;
      stat_total_o   <= '0;
      stat_min_o     <= LAT_WIDTH'(MIN_RESET);
      stat_max_o     <= '0;
      stat_timeout_o <= 1'b0;
    end else begin
      stat_count_o   <= sel_count;
      stat_total_o   <= sel_total;
      stat_min_o     <= sel_min;
      stat_max_o     <= sel_max;
      stat_timeout_o <= sel_timeout;
    end
  end

endmodule
